// File: rtl/sparse_act_packer.sv
// sparse_act_packer
// Feeds the sparse PE. Takes a dense stream of activations (one per cycle) for
// one input channel and drops the zeros. Surviving non-zeros are packed four at
// a time into a 4-lane beat that carries per-lane value, column and row. The
// beat that ends a channel also reports that channel's non-zero count.
module sparse_act_packer #(
    parameter int wordlength = 16,
    parameter int col_length = 5
) (
    input  logic                      clk,
    input  logic                      irst,
    input  logic                      act_valid,
    output logic                      act_ready,
    input  logic [wordlength-1:0]     act_data,
    input  logic [col_length-1:0]     act_col,
    input  logic [col_length-1:0]     act_row,
    input  logic [5:0]                act_channel,
    input  logic                      act_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*wordlength-1:0]   data_in,
    output logic [4*col_length-1:0]   data_in_cols,
    output logic [4*col_length-1:0]   data_in_rows,
    output logic [3:0]                lane_mask,
    output logic [5:0]                in_channel,
    output logic                      chan_done,
    output logic [15:0]               chan_nnz
);

    // Assembly stage: lanes that are filled but not yet complete
    logic [3:0][wordlength-1:0] asm_data;
    logic [3:0][col_length-1:0] asm_col;
    logic [3:0][col_length-1:0] asm_row;
    logic [1:0]                 fill;
    logic [15:0]                nnz;

    // Output stage: the beat currently presented to the PE
    logic [3:0][wordlength-1:0] out_data;
    logic [3:0][col_length-1:0] out_col;
    logic [3:0][col_length-1:0] out_row;
    logic [3:0]                 out_mask;
    logic [5:0]                 out_chan;
    logic                       out_done;
    logic [15:0]                out_nnz;
    logic                       out_vld;

    // Candidate beat assembled from held lanes plus the current activation
    logic [3:0][wordlength-1:0] nxt_data;
    logic [3:0][col_length-1:0] nxt_col;
    logic [3:0][col_length-1:0] nxt_row;
    logic [3:0]                 nxt_mask;

    logic        accept;
    logic        is_nz;
    logic        complete;
    logic [15:0] nnz_inc;
    logic [15:0] nnz_next;

    // Input stalls whenever a held beat has not been taken
    assign act_ready = !out_vld || out_ready;
    assign accept    = act_valid && act_ready;
    assign is_nz     = |act_data;

    // Count saturates rather than wrapping
    assign nnz_inc  = (nnz == 16'hFFFF) ? nnz : nnz + 16'd1;
    assign nnz_next = (accept && is_nz) ? nnz_inc : nnz;

    // A beat closes on the fourth non-zero or on any channel-final activation
    assign complete = accept && ((is_nz && (fill == 2'd3)) || act_last);

    // Merge held lanes with the incoming non-zero; unused lanes read as zero
    always_comb begin
        nxt_data = '0;
        nxt_col  = '0;
        nxt_row  = '0;
        nxt_mask = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k < 32'(fill)) begin
                nxt_data[k[1:0]] = asm_data[k[1:0]];
                nxt_col[k[1:0]]  = asm_col[k[1:0]];
                nxt_row[k[1:0]]  = asm_row[k[1:0]];
                nxt_mask[k[1:0]] = 1'b1;
            end else if ((k == 32'(fill)) && is_nz) begin
                nxt_data[k[1:0]] = act_data;
                nxt_col[k[1:0]]  = act_col;
                nxt_row[k[1:0]]  = act_row;
                nxt_mask[k[1:0]] = 1'b1;
            end
        end
    end

    // Assembly register: append non-zeros, restart on beat completion
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            asm_data <= '0;
            asm_col  <= '0;
            asm_row  <= '0;
            fill     <= '0;
            nnz      <= '0;
        end else if (accept) begin
            nnz <= act_last ? '0 : nnz_next;
            if (complete) begin
                fill <= '0;
            end else if (is_nz) begin
                asm_data[fill] <= act_data;
                asm_col[fill]  <= act_col;
                asm_row[fill]  <= act_row;
                fill           <= fill + 2'd1;
            end
        end
    end

    // Output register: load a completed beat, hold while stalled, drop on take
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            out_data <= '0;
            out_col  <= '0;
            out_row  <= '0;
            out_mask <= '0;
            out_chan <= '0;
            out_done <= 1'b0;
            out_nnz  <= '0;
            out_vld  <= 1'b0;
        end else if (complete) begin
            out_data <= nxt_data;
            out_col  <= nxt_col;
            out_row  <= nxt_row;
            out_mask <= nxt_mask;
            out_chan <= act_channel;
            out_done <= act_last;
            out_nnz  <= act_last ? nnz_next : 16'd0;
            out_vld  <= 1'b1;
        end else if (out_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign out_valid    = out_vld;
    assign data_in      = out_data;
    assign data_in_cols = out_col;
    assign data_in_rows = out_row;
    assign lane_mask    = out_mask;
    assign in_channel   = out_chan;
    assign chan_done    = out_done;
    assign chan_nnz     = out_nnz;

endmodule

// File: tb/tb_sparse_act_packer.sv
// Testbench for sparse_act_packer: directed scenarios plus a randomized stream
// with random backpressure, checked against a queue-based packing model.
module tb_sparse_act_packer;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  col;
        logic [4:0]  row;
        logic [5:0]  ch;
        logic        last;
    } act_t;

    typedef struct packed {
        logic [63:0] data;
        logic [19:0] cols;
        logic [19:0] rows;
        logic [3:0]  mask;
        logic [5:0]  ch;
        logic        done;
        logic [15:0] nnz;
    } beat_t;

    logic        clk = 1'b0;
    logic        irst;
    logic        act_valid;
    logic        act_ready;
    logic [15:0] act_data;
    logic [4:0]  act_col;
    logic [4:0]  act_row;
    logic [5:0]  act_channel;
    logic        act_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_in;
    logic [19:0] data_in_cols;
    logic [19:0] data_in_rows;
    logic [3:0]  lane_mask;
    logic [5:0]  in_channel;
    logic        chan_done;
    logic [15:0] chan_nnz;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    act_t  chan_q[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    int    acc_cyc[$];

    sparse_act_packer #(.wordlength(16), .col_length(5)) dut (
        .clk(clk), .irst(irst),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .act_col(act_col), .act_row(act_row), .act_channel(act_channel), .act_last(act_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_in(data_in), .data_in_cols(data_in_cols), .data_in_rows(data_in_rows),
        .lane_mask(lane_mask), .in_channel(in_channel), .chan_done(chan_done), .chan_nnz(chan_nnz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t cur_beat();
        beat_t b;
        b.data = data_in;
        b.cols = data_in_cols;
        b.rows = data_in_rows;
        b.mask = lane_mask;
        b.ch   = in_channel;
        b.done = chan_done;
        b.nnz  = chan_nnz;
        return b;
    endfunction

    // Record every beat the PE takes (valid and ready at the sampling point)
    always @(negedge clk) begin
        if (!irst && out_valid && out_ready) begin
            got_q.push_back(cur_beat());
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic act_t mk(input logic [15:0] d, input int c, input int r, input int ch, input bit l);
        act_t a;
        a.data = d;
        a.col  = 5'(c);
        a.row  = 5'(r);
        a.ch   = 6'(ch);
        a.last = l;
        return a;
    endfunction

    // Reference: collect non-zeros in arrival order; close a beat at four
    // lanes or at a channel-final activation; report the count on the last.
    task automatic model_stream();
        beat_t b;
        int n;
        int unsigned cnt;
        b = '0;
        n = 0;
        cnt = 0;
        foreach (chan_q[i]) begin
            if (chan_q[i].data != 16'd0) begin
                b.data[16*n +: 16] = chan_q[i].data;
                b.cols[5*n +: 5]   = chan_q[i].col;
                b.rows[5*n +: 5]   = chan_q[i].row;
                b.mask[n]          = 1'b1;
                n++;
                if (cnt < 65535) cnt++;
            end
            if (n == 4 || chan_q[i].last) begin
                b.ch   = chan_q[i].ch;
                b.done = chan_q[i].last;
                b.nnz  = chan_q[i].last ? 16'(cnt) : 16'd0;
                exp_q.push_back(b);
                b = '0;
                n = 0;
                if (chan_q[i].last) cnt = 0;
            end
        end
    endtask

    // Present one activation until accepted; called in the posedge+1 phase
    task automatic send(input act_t a);
        int waited;
        waited = 0;
        act_valid   = 1'b1;
        act_data    = a.data;
        act_col     = a.col;
        act_row     = a.row;
        act_channel = a.ch;
        act_last    = a.last;
        forever begin
            @(negedge clk);
            if (act_ready) break;
            waited++;
            if (waited > 300) begin
                checks++;
                failures++;
                $display("FAIL send_timeout act_ready=%0b required=1", act_ready);
                break;
            end
        end
        acc_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        act_valid = 1'b0;
        act_last  = 1'b0;
    endtask

    task automatic send_all();
        foreach (chan_q[i]) send(chan_q[i]);
    endtask

    task automatic clear_all();
        chan_q.delete();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic drain();
        int w;
        w = 0;
        out_ready = 1'b1;
        while (got_q.size() < exp_q.size() && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        beat_t zero_b;
        zero_b = '0;
        irst = 1'b1;
        act_valid = 1'b0; act_data = '0; act_col = '0; act_row = '0;
        act_channel = '0; act_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cur_beat() !== zero_b || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h valid=%0b exp=0", cur_beat(), out_valid);
        end
        checks++;
        if (act_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_act_ready got=%0b exp=1", act_ready);
        end
        @(posedge clk);
        #1;
        irst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || act_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle valid=%0b ready=%0b exp valid=0 ready=1", out_valid, act_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dense();
        clear_all();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) chan_q.push_back(mk(16'(i + 1), i, 0, 3, i == 7));
        model_stream();
        send_all();
        drain();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL dense_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL dense_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() == 2 && acc_cyc.size() == 8) begin
            checks++;
            if (got_cyc[0] !== acc_cyc[3] + 1) begin
                failures++;
                $display("FAIL dense_latency_a got=%0d exp=%0d", got_cyc[0], acc_cyc[3] + 1);
            end
            checks++;
            if (got_cyc[1] !== acc_cyc[7] + 1) begin
                failures++;
                $display("FAIL dense_latency_b got=%0d exp=%0d", got_cyc[1], acc_cyc[7] + 1);
            end
        end
    endtask

    task automatic test_sparse();
        beat_t want;
        clear_all();
        out_ready = 1'b1;
        chan_q.push_back(mk(16'h0000, 0, 0, 2, 0));
        chan_q.push_back(mk(16'd5,    2, 1, 2, 0));
        chan_q.push_back(mk(16'h0000, 3, 3, 2, 0));
        chan_q.push_back(mk(16'd7,    4, 3, 2, 0));
        chan_q.push_back(mk(16'h0000, 5, 5, 2, 1));
        send_all();
        drain();
        want = '0;
        want.data = {16'd0, 16'd0, 16'd7, 16'd5};
        want.cols = {5'd0, 5'd0, 5'd4, 5'd2};
        want.rows = {5'd0, 5'd0, 5'd3, 5'd1};
        want.mask = 4'b0011;
        want.ch   = 6'd2;
        want.done = 1'b1;
        want.nnz  = 16'd2;
        checks++;
        if (got_q.size() !== 1) begin
            failures++;
            $display("FAIL sparse_count got=%0d exp=1", got_q.size());
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== want) begin
                failures++;
                $display("FAIL sparse_beat got=%h exp=%h", got_q[0], want);
            end
        end
    endtask

    task automatic test_all_zero();
        beat_t want;
        clear_all();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) chan_q.push_back(mk(16'h0000, i + 1, i + 2, 9, i == 3));
        send_all();
        drain();
        want = '0;
        want.ch   = 6'd9;
        want.done = 1'b1;
        checks++;
        if (got_q.size() !== 1) begin
            failures++;
            $display("FAIL zero_chan_count got=%0d exp=1", got_q.size());
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== want) begin
                failures++;
                $display("FAIL zero_chan_beat got=%h exp=%h", got_q[0], want);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) chan_q.push_back(mk(16'(100 + i), i, i / 4, 5, i == 11));
        model_stream();
        fork
            send_all();
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    checks++;
                    if (act_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_act_ready cycle%0d got=%0b exp=0", i, act_ready);
                    end
                    checks++;
                    if (out_valid !== 1'b1 || cur_beat() !== exp_q[0]) begin
                        failures++;
                        $display("FAIL stall_hold cycle%0d valid=%0b got=%h exp=%h", i, out_valid, cur_beat(), exp_q[0]);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t zero_b;
        zero_b = '0;
        clear_all();
        out_ready = 1'b1;
        send(mk(16'd11, 7, 7, 4, 0));
        send(mk(16'd12, 8, 7, 4, 0));
        irst = 1'b1;
        @(negedge clk);
        checks++;
        if (cur_beat() !== zero_b || out_valid !== 1'b0 || act_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_outputs got=%h valid=%0b ready=%0b exp=0/0/1", cur_beat(), out_valid, act_ready);
        end
        @(posedge clk);
        #1;
        irst = 1'b0;
        got_q.delete();
        for (int i = 0; i < 4; i++) chan_q.push_back(mk(16'(i + 1), i, 1, 4, i == 3));
        model_stream();
        send_all();
        drain();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL midreset_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_edge_values();
        beat_t want;
        clear_all();
        out_ready = 1'b1;
        chan_q.push_back(mk(16'hFFFF, 0, 0, 1, 0));
        chan_q.push_back(mk(16'h8000, 1, 0, 1, 0));
        chan_q.push_back(mk(16'h0001, 2, 0, 1, 0));
        chan_q.push_back(mk(16'h0000, 3, 0, 1, 0));
        chan_q.push_back(mk(16'h7FFF, 4, 0, 1, 1));
        send_all();
        drain();
        want = '0;
        want.data = {16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF};
        want.cols = {5'd4, 5'd2, 5'd1, 5'd0};
        want.mask = 4'b1111;
        want.ch   = 6'd1;
        want.done = 1'b1;
        want.nnz  = 16'd4;
        checks++;
        if (got_q.size() !== 1) begin
            failures++;
            $display("FAIL edge_count got=%0d exp=1", got_q.size());
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== want) begin
                failures++;
                $display("FAIL edge_beat got=%h exp=%h", got_q[0], want);
            end
        end
    endtask

    task automatic test_random();
        bit busy;
        clear_all();
        for (int c = 0; c < 25; c++) begin
            int len;
            int ch;
            len = $urandom_range(1, 10);
            ch  = $urandom_range(0, 63);
            for (int i = 0; i < len; i++) begin
                logic [15:0] d;
                d = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
                chan_q.push_back(mk(d, $urandom_range(0, 31), $urandom_range(0, 31), ch, i == len - 1));
            end
        end
        model_stream();
        busy = 1'b1;
        fork
            begin
                send_all();
                busy = 1'b0;
            end
            begin
                while (busy) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dense();
        test_sparse();
        test_all_zero();
        test_backpressure();
        test_reset_mid();
        test_edge_values();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
